// File: rtl/pe_vec_pkg.sv
// Shared types, instruction field layout and helpers for the PE vector engine.
package pe_vec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef enum logic [3:0] {
        OP_PASS = 4'd0,
        OP_MAC  = 4'd1,
        OP_ACT  = 4'd2,
        OP_NORM = 4'd3
    } opcode_e;

    localparam logic [7:0] ACT_RELU  = 8'd0;
    localparam logic [7:0] ACT_LEAKY = 8'd1;

    localparam int unsigned OPC_LSB  = 28;
    localparam int unsigned OPC_W    = 4;
    localparam int unsigned N_LSB    = 8;
    localparam int unsigned N_W      = 16;
    localparam int unsigned FUNC_LSB = 0;
    localparam int unsigned FUNC_W   = 8;

    function automatic logic is_legal_op(input logic [3:0] opc);
        return opc <= 4'd3;
    endfunction

    // Clamp a signed value into the signed range of a dw-bit word (dw <= 64).
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                      input int unsigned      dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/pe_lane_alu.sv
// One lane of the vector engine: combinational PASS/ACT/NORM result and MAC product.
module pe_lane_alu
    import pe_vec_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  opcode_e                        op,
    input  logic [7:0]                     func,
    input  logic signed [DATA_WIDTH-1:0]   a,
    input  logic signed [DATA_WIDTH-1:0]   b,
    output logic [DATA_WIDTH-1:0]          res,
    output logic signed [2*DATA_WIDTH-1:0] prod
);

    localparam logic [7:0] S_MAX = 8'(DATA_WIDTH - 1);

    logic signed [2*DATA_WIDTH-1:0] a_w;
    logic signed [2*DATA_WIDTH-1:0] b_w;
    logic [7:0]                     shamt;
    logic signed [DATA_WIDTH:0]     rounded;
    logic signed [DATA_WIDTH:0]     shifted;

    assign a_w  = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
    assign b_w  = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
    assign prod = a_w * b_w;

    always_comb begin
        shamt   = (func > S_MAX) ? S_MAX : func;
        rounded = {a[DATA_WIDTH-1], a};
        // One guard bit keeps the rounding add from overflowing before the shift.
        if (shamt != '0) begin
            rounded = rounded + ((DATA_WIDTH + 1)'(1) << (shamt - 8'd1));
        end
        shifted = rounded >>> shamt;

        res = a;
        case (op)
            OP_ACT: begin
                if (a[DATA_WIDTH-1]) begin
                    if (func == ACT_RELU) begin
                        res = '0;
                    end else if (func == ACT_LEAKY) begin
                        res = DATA_WIDTH'(a >>> 3);
                    end
                end
            end
            OP_NORM: res = DATA_WIDTH'(sat_signed(64'(shifted), DATA_WIDTH));
            default: res = a;
        endcase
    end

endmodule

// File: rtl/pe_vec_engine.sv
// Handshaked PE vector engine: streams N beats of LANES elements through
// PASS, MAC-reduce, ACT or NORM, with a done pulse on completion.
module pe_vec_engine
    import pe_vec_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LANES      = 8,
    parameter int unsigned ACC_WIDTH  = 40,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        instr_valid,
    output logic                        instr_ready,
    input  logic [31:0]                 instr,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] in_a,
    input  logic [LANES*DATA_WIDTH-1:0] in_b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    state_e                         state_q, state_d;
    opcode_e                        op_q, op_d;
    logic [7:0]                     func_q, func_d;
    logic [CNT_WIDTH-1:0]           n_q, n_d;
    logic [CNT_WIDTH-1:0]           cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0]    acc_q [LANES];
    logic signed [ACC_WIDTH-1:0]    acc_d [LANES];
    logic                           out_valid_q, out_valid_d;
    logic [LANES*DATA_WIDTH-1:0]    out_data_q, out_data_d;
    logic                           err_q, err_d;

    logic [LANES*DATA_WIDTH-1:0]    alu_res;
    logic signed [2*DATA_WIDTH-1:0] prod [LANES];
    logic [3:0]                     instr_op;
    logic [CNT_WIDTH-1:0]           instr_n;
    logic                           in_fire;
    logic                           out_fire;
    logic                           last_beat;
    logic                           unused_rsvd;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pe_lane_alu #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_alu (
            .op  (op_q),
            .func(func_q),
            .a   (in_a[i*DATA_WIDTH +: DATA_WIDTH]),
            .b   (in_b[i*DATA_WIDTH +: DATA_WIDTH]),
            .res (alu_res[i*DATA_WIDTH +: DATA_WIDTH]),
            .prod(prod[i])
        );
    end

    assign instr_op    = instr[OPC_LSB +: OPC_W];
    assign instr_n     = CNT_WIDTH'(instr[N_LSB +: N_W]);
    assign unused_rsvd = ^instr[27:24];

    assign instr_ready = (state_q == ST_IDLE);
    assign in_ready    = (state_q == ST_RUN) && ((op_q == OP_MAC) || !out_valid_q || out_ready);
    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid_q && out_ready;
    assign last_beat   = (cnt_q == n_q - CNT_WIDTH'(1));

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        func_d      = func_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    if (is_legal_op(instr_op)) begin
                        op_d    = opcode_e'(instr_op);
                        func_d  = instr[FUNC_LSB +: FUNC_W];
                        n_d     = (instr_n == '0) ? CNT_WIDTH'(1) : instr_n;
                        cnt_d   = '0;
                        for (int unsigned i = 0; i < LANES; i++) acc_d[i] = '0;
                        state_d = ST_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (op_q == OP_MAC) begin
                    if (in_fire) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                        for (int unsigned i = 0; i < LANES; i++) begin
                            acc_d[i] = acc_q[i] + ACC_WIDTH'(prod[i]);
                        end
                        // The final beat's sum is saturated straight into the output register.
                        if (last_beat) begin
                            for (int unsigned i = 0; i < LANES; i++) begin
                                out_data_d[i*DATA_WIDTH +: DATA_WIDTH] =
                                    DATA_WIDTH'(sat_signed(64'(acc_d[i]), DATA_WIDTH));
                            end
                            out_valid_d = 1'b1;
                            state_d     = ST_DRAIN;
                        end
                    end
                end else begin
                    if (in_fire) begin
                        out_data_d  = alu_res;
                        out_valid_d = 1'b1;
                        cnt_d       = cnt_q + CNT_WIDTH'(1);
                        if (last_beat) state_d = ST_DRAIN;
                    end else if (out_fire) begin
                        out_valid_d = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_fire) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_PASS;
            func_q      <= '0;
            n_q         <= '0;
            cnt_q       <= '0;
            for (int unsigned i = 0; i < LANES; i++) acc_q[i] <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            func_q      <= func_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_pe_vec_engine.sv
// Self-checking bench for pe_vec_engine with DATA_WIDTH=16, LANES=4.
module tb_pe_vec_engine;

    localparam int DW = 16;
    localparam int LN = 4;
    localparam int VW = DW * LN;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [31:0]   instr = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [VW-1:0] in_a = '0;
    logic [VW-1:0] in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [VW-1:0] out_data;
    logic          busy, done, err;

    int n_chk = 0, n_fail = 0, tmo = 0;
    int rdy_mode = 0;

    int            cyc = 0, done_n = 0, err_n = 0, done_cyc = 0, stall_viol = 0;
    int            in_cyc[$], out_cyc[$];
    logic [VW-1:0] out_q[$], exp_q[$], ba[$], bb[$];
    logic          stall_pend = 1'b0;
    logic [VW-1:0] stall_data = '0;

    pe_vec_engine #(
        .DATA_WIDTH(DW),
        .LANES     (LN),
        .ACC_WIDTH (40),
        .CNT_WIDTH (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int m_sat(input longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return int'(x);
    endfunction

    function automatic int m_act(input int x, input int f);
        if (x >= 0) return x;
        if (f == 0) return 0;
        if (f == 1) return (x - 7) / 8;
        return x;
    endfunction

    function automatic int m_norm(input int x, input int f);
        int s;
        longint d, v, q;
        s = (f > DW - 1) ? DW - 1 : f;
        if (s == 0) return x;
        d = longint'(1) << s;
        v = longint'(x) + d / 2;
        q = (v >= 0) ? v / d : -((-v + d - 1) / d);
        return m_sat(q);
    endfunction

    function automatic int lane(input logic [VW-1:0] v, input int i);
        logic [DW-1:0] e;
        e = v[i*DW +: DW];
        return int'($signed(e));
    endfunction

    function automatic logic [VW-1:0] vec(input int e0, input int e1, input int e2, input int e3);
        return {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
    endfunction

    function automatic logic [VW-1:0] m_stream(input int op, input int f, input logic [VW-1:0] a);
        logic [VW-1:0] r;
        int y;
        r = '0;
        for (int i = 0; i < LN; i++) begin
            case (op)
                2:       y = m_act(lane(a, i), f);
                3:       y = m_norm(lane(a, i), f);
                default: y = lane(a, i);
            endcase
            r[i*DW +: DW] = y[DW-1:0];
        end
        return r;
    endfunction

    // ---------------- monitor and out_ready driver ----------------
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            stall_pend = 1'b0;
        end else begin
            if (in_valid && in_ready) in_cyc.push_back(cyc);
            if (out_valid && out_ready) begin
                out_q.push_back(out_data);
                out_cyc.push_back(cyc);
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (err) err_n++;
            if (stall_pend && (!out_valid || out_data !== stall_data)) stall_viol++;
            stall_pend = out_valid && !out_ready;
            stall_data = out_data;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            1:       out_ready = ~out_ready;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
        endcase
    end

    // ---------------- stimulus driver ----------------
    task automatic clear_mon();
        in_cyc.delete(); out_cyc.delete(); out_q.delete();
        done_n = 0; err_n = 0; done_cyc = 0; stall_viol = 0;
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] f, input logic [15:0] n,
                         input bit wait_done);
        int w;
        clear_mon();
        instr = {op, 4'h0, n, f};
        instr_valid = 1'b1;
        w = 0;
        do begin @(negedge clk); w++; end while (!instr_ready && w < 200);
        if (w >= 200) tmo++;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        foreach (ba[k]) begin
            in_a = ba[k]; in_b = bb[k]; in_valid = 1'b1;
            w = 0;
            do begin @(negedge clk); w++; end while (!in_ready && w < 200);
            if (w >= 200) tmo++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (wait_done) begin
            w = 0;
            while (done_n == 0 && w < 400) begin @(negedge clk); w++; end
            if (done_n == 0) tmo++;
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        n_chk++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_instr_ready got %b want 1", instr_ready); end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_chk++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
        n_chk++; if ({busy, done, err} !== 3'b000) begin n_fail++; $display("FAIL reset_busy_done_err got %b want 000", {busy, done, err}); end
    endtask

    task automatic test_pass();
        int lc;
        ba.delete(); bb.delete();
        for (int k = 1; k <= 3; k++) begin
            ba.push_back(vec(k, -k, 100 * k, k + 7)); bb.push_back('0);
        end
        rdy_mode = 0;
        drive(4'd0, 8'd0, 16'd3, 1'b1);
        n_chk++; if (out_q.size() != 3) begin n_fail++; $display("FAIL pass_count got %0d want 3", out_q.size()); end
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (k >= out_q.size() || out_q[k] !== ba[k]) begin
                n_fail++; $display("FAIL pass_data[%0d] got %h want %h", k, (k < out_q.size()) ? out_q[k] : '0, ba[k]);
            end
            n_chk++;
            if (k >= out_cyc.size() || k >= in_cyc.size() || out_cyc[k] != in_cyc[k] + 1) begin
                n_fail++; $display("FAIL pass_latency[%0d] got out/in cycle mismatch want latency 1", k);
            end
        end
        n_chk++; if (in_cyc.size() != 3 || in_cyc[2] != in_cyc[0] + 2) begin n_fail++; $display("FAIL pass_rate got %0d inputs not back-to-back want 3 consecutive", in_cyc.size()); end
        n_chk++; if (done_n != 1) begin n_fail++; $display("FAIL pass_done_count got %0d want 1", done_n); end
        lc = (out_cyc.size() == 3) ? out_cyc[2] + 1 : -100;
        n_chk++; if (done_cyc != lc) begin n_fail++; $display("FAIL pass_done_cycle got %0d want %0d", done_cyc, lc); end
    endtask

    task automatic test_mac();
        logic [VW-1:0] want;
        ba.delete(); bb.delete();
        for (int k = 0; k < 2; k++) begin
            ba.push_back(vec(2, -3, 100, 32767)); bb.push_back(vec(3, 4, 100, 32767));
        end
        want = vec(12, -24, 20000, 32767);
        rdy_mode = 0;
        drive(4'd1, 8'd0, 16'd2, 1'b1);
        n_chk++; if (out_q.size() != 1) begin n_fail++; $display("FAIL mac_count got %0d want 1", out_q.size()); end
        n_chk++; if (out_q.size() < 1 || out_q[0] !== want) begin n_fail++; $display("FAIL mac_data got %h want %h", (out_q.size() > 0) ? out_q[0] : '0, want); end
        n_chk++; if (done_n != 1) begin n_fail++; $display("FAIL mac_done got %0d want 1", done_n); end
    endtask

    task automatic test_act();
        logic [VW-1:0] want;
        ba.delete(); bb.delete();
        ba.push_back(vec(-16, -1, 5, 0)); bb.push_back('0);
        for (int f = 1; f >= 0; f--) begin
            want = (f == 1) ? vec(-2, -1, 5, 0) : vec(0, 0, 5, 0);
            drive(4'd2, 8'(f), 16'd1, 1'b1);
            n_chk++; if (out_q.size() != 1 || out_q[0] !== want) begin n_fail++; $display("FAIL act_f%0d got %h (n=%0d) want %h", f, (out_q.size() > 0) ? out_q[0] : '0, out_q.size(), want); end
        end
    endtask

    task automatic test_norm();
        logic [VW-1:0] want [3];
        logic [7:0]    fs [3];
        fs[0] = 8'd2;   want[0] = vec(2, -2, 16'h2000, -8192);
        fs[1] = 8'd1;   want[1] = vec(16'h4000, 1, 0, 0);
        fs[2] = 8'd200; want[2] = vec(1, -1, 1, 0);
        for (int t = 0; t < 3; t++) begin
            ba.delete(); bb.delete(); bb.push_back('0);
            case (t)
                0:       ba.push_back(vec(7, -7, 32767, -32768));
                1:       ba.push_back(vec(32767, 1, -1, 0));
                default: ba.push_back(vec(32767, -32768, 16384, -1));
            endcase
            drive(4'd3, fs[t], 16'd1, 1'b1);
            n_chk++; if (out_q.size() != 1 || out_q[0] !== want[t]) begin n_fail++; $display("FAIL norm_s%0d got %h (n=%0d) want %h", fs[t], (out_q.size() > 0) ? out_q[0] : '0, out_q.size(), want[t]); end
        end
    endtask

    task automatic test_backpressure();
        ba.delete(); bb.delete();
        for (int k = 0; k < 4; k++) begin ba.push_back({$urandom, $urandom}); bb.push_back('0); end
        rdy_mode = 1;
        drive(4'd0, 8'd0, 16'd4, 1'b1);
        rdy_mode = 0;
        n_chk++; if (out_q.size() != 4) begin n_fail++; $display("FAIL bp_count got %0d want 4", out_q.size()); end
        for (int k = 0; k < 4; k++) begin
            n_chk++; if (k >= out_q.size() || out_q[k] !== ba[k]) begin n_fail++; $display("FAIL bp_data[%0d] got %h want %h", k, (k < out_q.size()) ? out_q[k] : '0, ba[k]); end
        end
        n_chk++; if (stall_viol != 0) begin n_fail++; $display("FAIL bp_stable got %0d unstable stalls want 0", stall_viol); end
        n_chk++; if (done_n != 1) begin n_fail++; $display("FAIL bp_done got %0d want 1", done_n); end
    endtask

    task automatic test_illegal();
        int rdy_seen;
        ba.delete(); bb.delete();
        drive(4'd9, 8'd0, 16'd1, 1'b0);
        rdy_seen = 0;
        repeat (4) begin @(negedge clk); if (in_ready) rdy_seen++; end
        @(posedge clk); #1;
        n_chk++; if (err_n != 1) begin n_fail++; $display("FAIL illegal_err_pulses got %0d want 1", err_n); end
        n_chk++; if (instr_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL illegal_idle got ready=%b busy=%b want 1/0", instr_ready, busy); end
        n_chk++; if (rdy_seen != 0) begin n_fail++; $display("FAIL illegal_in_ready got %0d cycles want 0", rdy_seen); end
    endtask

    task automatic test_reset_mid_op();
        ba.delete(); bb.delete();
        for (int k = 0; k < 2; k++) begin ba.push_back(vec(5, 6, 7, 8)); bb.push_back(vec(1, 1, 1, 1)); end
        drive(4'd1, 8'd0, 16'd5, 1'b0);
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before got %b want 1", busy); end
        rst_n = 1'b0;
        @(negedge clk);
        n_chk++; if ({instr_ready, in_ready, out_valid, busy, done, err} !== 6'b100000) begin n_fail++; $display("FAIL midrst_ctrl got %b want 100000", {instr_ready, in_ready, out_valid, busy, done, err}); end
        n_chk++; if (out_data !== '0) begin n_fail++; $display("FAIL midrst_out_data got %h want 0", out_data); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        ba.delete(); bb.delete();
        for (int k = 0; k < 2; k++) begin ba.push_back(vec(-100 * k, 3, k, -1)); bb.push_back('0); end
        drive(4'd0, 8'd0, 16'd2, 1'b1);
        n_chk++; if (out_q.size() != 2 || out_q[0] !== ba[0] || out_q[1] !== ba[1]) begin n_fail++; $display("FAIL midrst_pass got n=%0d first=%h want 2 beats first=%h", out_q.size(), (out_q.size() > 0) ? out_q[0] : '0, ba[0]); end
        n_chk++; if (done_n != 1) begin n_fail++; $display("FAIL midrst_done got %0d want 1", done_n); end
    endtask

    task automatic test_random();
        int op, f, n, neff;
        longint acc [LN];
        logic [VW-1:0] r;
        rdy_mode = 2;
        for (int t = 0; t < 16; t++) begin
            op = int'($urandom_range(0, 3));
            f  = (op == 2) ? int'($urandom_range(0, 3)) : (op == 3) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 255));
            n  = int'($urandom_range(0, 6));
            neff = (n == 0) ? 1 : n;
            ba.delete(); bb.delete(); exp_q.delete();
            for (int i = 0; i < LN; i++) acc[i] = 0;
            for (int k = 0; k < neff; k++) begin
                ba.push_back({$urandom, $urandom}); bb.push_back({$urandom, $urandom});
                if (op == 1) begin
                    for (int i = 0; i < LN; i++) acc[i] += longint'(lane(ba[k], i)) * longint'(lane(bb[k], i));
                end else begin
                    exp_q.push_back(m_stream(op, f, ba[k]));
                end
            end
            if (op == 1) begin
                r = '0;
                for (int i = 0; i < LN; i++) r[i*DW +: DW] = 16'(m_sat(acc[i]));
                exp_q.push_back(r);
            end
            drive(4'(op), 8'(f), 16'(n), 1'b1);
            n_chk++; if (out_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_count op=%0d got %0d want %0d", t, op, out_q.size(), exp_q.size()); end
            foreach (exp_q[k]) begin
                n_chk++; if (k >= out_q.size() || out_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rand%0d_data[%0d] op=%0d f=%0d got %h want %h", t, k, op, f, (k < out_q.size()) ? out_q[k] : '0, exp_q[k]); end
            end
            n_chk++; if (done_n != 1) begin n_fail++; $display("FAIL rand%0d_done got %0d want 1", t, done_n); end
        end
        rdy_mode = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        test_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_pass();
        test_mac();
        test_act();
        test_norm();
        test_backpressure();
        test_illegal();
        test_reset_mid_op();
        test_random();
        n_chk++; if (tmo != 0) begin n_fail++; $display("FAIL handshake_timeouts got %0d want 0", tmo); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got no completion want finish");
        $fatal(1, "bench timeout");
    end

endmodule
